nios2_ocimem_monitor: RTL and testbench

On-chip debug monitor memory and mailbox for the Nios II JTAG debug path, in the `clk` domain. It consumes the decoded `jdo` word and the `take_action_ocimem_*` strobes produced by the JTAG debug module. It returns `MonDReg`, `monitor_ready` and `monitor_error` to that module for shifting out. It also exposes the same RAM, plus a status register, to the CPU's debug-monitor code through an Avalon-MM slave port.

---
 rtl/nios2_ocimem_pkg.sv | 30 +++
 rtl/nios2_ocimem_monitor_if.sv | 23 ++
 rtl/nios2_ocimem_ram.sv | 26 ++
 rtl/nios2_ocimem_monitor.sv | 184 ++++++++++++++++++
 tb/tb_nios2_ocimem_monitor.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_ocimem_pkg.sv
// Shared constants and types for the Nios II OCI debug monitor memory.
package nios2_ocimem_pkg;

  // Width of the decoded JTAG command/data word.
  localparam int JDO_W = 38;

  // Bit positions inside jdo.
  localparam int ADDR_LSB    = 17;
  localparam int DATA_LSB    = 3;
  localparam int RD_BIT      = 34;
  localparam int CLR_RDY_BIT = 35;
  localparam int CLR_ERR_BIT = 36;

  // Word offsets inside the register space (selected by address[0]).
  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_ADDR   = 1'b1;

  // Arbiter states: idle, JTAG read completing, CPU read completing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JRD  = 2'd1,
    ST_CRD  = 2'd2
  } state_t;

  // Status register image as seen by the CPU.
  function automatic logic [31:0] status_word(input logic err, input logic rdy);
    return {30'b0, err, rdy};
  endfunction

endpackage

// File: rtl/nios2_ocimem_monitor_if.sv
// Avalon-MM slave bus through which the CPU debug code reaches the monitor.
interface nios2_ocimem_monitor_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W:0] address;
  logic            chipselect;
  logic            read;
  logic            write;
  logic [31:0]     writedata;
  logic [3:0]      byteenable;
  logic [31:0]     readdata;
  logic            waitrequest;

  modport master (
    output address, chipselect, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/nios2_ocimem_ram.sv
// Single-port synchronous RAM, 32-bit words with byte enables and a
// registered read port (read-before-write), shaped for block-RAM inference.
module nios2_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  // Byte-lane write and registered read on the shared port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/nios2_ocimem_monitor.sv
// Debug monitor RAM and mailbox shared between the JTAG debug path and the
// CPU's Avalon-MM port. JTAG traffic always has priority over the CPU.
module nios2_ocimem_monitor
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  nios2_ocimem_monitor_if.slave avs
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] mon_areg;
  logic              pend_valid;
  logic              pend_wr;
  logic [31:0]       pend_data;
  logic              crd_is_reg;
  logic [31:0]       crd_reg_data;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic              rd_strobe, wr_strobe, jtag_busy, idle;
  logic              cpu_rd, cpu_wr, cpu_reg, cpu_grant;
  logic              cpu_rd_now, cpu_wr_now;
  logic              jtag_wr_now, pend_wr_now, pend_rd_now;
  logic              set_rdy, set_err, clr_rdy, clr_err;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // jdo[37] and jdo[2:0] carry nothing this block decodes.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1], jdo[DATA_LSB-1:0]};

  assign jdo_addr  = jdo[ADDR_LSB +: ADDR_W];
  assign jdo_data  = jdo[DATA_LSB +: 32];
  assign rd_strobe = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[RD_BIT]);
  assign wr_strobe = take_action_ocimem_b;
  assign idle      = (state == ST_IDLE);

  // Any JTAG access arriving or waiting locks the CPU out of the port.
  assign jtag_busy = pend_valid | rd_strobe | wr_strobe;

  assign cpu_rd    = avs.chipselect & avs.read;
  assign cpu_wr    = avs.chipselect & avs.write & ~avs.read;
  assign cpu_reg   = avs.address[ADDR_W];
  assign cpu_grant = idle & ~jtag_busy;
  assign cpu_rd_now = cpu_grant & cpu_rd;
  assign cpu_wr_now = cpu_grant & cpu_wr;

  // A JTAG write arriving while idle retires on its own strobe edge, so the
  // written word is visible to the very next access; otherwise it waits.
  assign jtag_wr_now = idle & wr_strobe;
  assign pend_wr_now = idle & ~wr_strobe & pend_valid & pend_wr;
  assign pend_rd_now = idle & ~wr_strobe & pend_valid & ~pend_wr;

  assign set_rdy = cpu_wr_now & cpu_reg & (avs.address[0] == REG_STATUS) & avs.writedata[0];
  assign set_err = cpu_wr_now & cpu_reg & (avs.address[0] == REG_STATUS) & avs.writedata[1];
  assign clr_rdy = take_action_ocimem_a & jdo[CLR_RDY_BIT];
  assign clr_err = take_action_ocimem_a & jdo[CLR_ERR_BIT];

  // CPU read data only drives the bus in the cycle the read completes.
  assign avs.readdata    = (state == ST_CRD) ? (crd_is_reg ? crd_reg_data : ram_rdata) : 32'h0;
  assign avs.waitrequest = (cpu_rd & (state != ST_CRD)) | (cpu_wr & ~cpu_grant);

  // RAM port steering: JTAG first, then CPU RAM-space accesses.
  always_comb begin
    ram_addr  = mon_areg;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = pend_data;
    if (jtag_wr_now) begin
      ram_we    = 1'b1;
      ram_wdata = jdo_data;
    end else if (pend_wr_now) begin
      ram_we    = 1'b1;
    end else if (cpu_grant & ~cpu_reg & (cpu_rd | cpu_wr)) begin
      ram_addr  = avs.address[ADDR_W-1:0];
      ram_we    = cpu_wr;
      ram_be    = avs.byteenable;
      ram_wdata = avs.writedata;
    end
  end

  // Next-state logic: a pending JTAG read beats a CPU read.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pend_rd_now)     state_next = ST_JRD;
        else if (cpu_rd_now) state_next = ST_CRD;
      end
      ST_JRD:  state_next = ST_IDLE;
      ST_CRD:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // One-deep JTAG command capture; a newer strobe replaces an older one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_data  <= 32'h0;
    end else if (wr_strobe) begin
      pend_valid <= ~idle;
      pend_wr    <= 1'b1;
      pend_data  <= jdo_data;
    end else if (rd_strobe) begin
      pend_valid <= 1'b1;
      pend_wr    <= 1'b0;
    end else if (pend_wr_now | pend_rd_now) begin
      pend_valid <= 1'b0;
    end
  end

  // JTAG address register: explicit load, else post-increment per access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mon_areg <= '0;
    else if (take_action_ocimem_a)
      mon_areg <= jdo_addr;
    else if (jtag_wr_now | pend_wr_now | (state == ST_JRD))
      mon_areg <= mon_areg + ADDR_W'(1);
  end

  // JTAG readback register loads the RAM word fetched in the previous cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              MonDReg <= 32'h0;
    else if (state == ST_JRD)  MonDReg <= ram_rdata;
  end

  // Mailbox flags: CPU sets, JTAG clears, clear wins on collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (clr_rdy)      monitor_ready <= 1'b0;
      else if (set_rdy) monitor_ready <= 1'b1;
      if (clr_err)      monitor_error <= 1'b0;
      else if (set_err) monitor_error <= 1'b1;
    end
  end

  // Register-space reads are sampled at issue so both read paths take 2 cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crd_is_reg   <= 1'b0;
      crd_reg_data <= 32'h0;
    end else if (cpu_rd_now) begin
      crd_is_reg   <= cpu_reg;
      crd_reg_data <= (avs.address[0] == REG_ADDR) ? 32'(mon_areg)
                                                   : status_word(monitor_error, monitor_ready);
    end
  end

  nios2_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_nios2_ocimem_monitor.sv
// Directed bench for the OCI debug monitor: JTAG path, CPU path, flags,
// arbitration and reset behaviour, with hand-computed expectations.
module tb_nios2_ocimem_monitor;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int errors = 0;
  int checks = 0;

  nios2_ocimem_monitor_if #(.ADDR_W(AW)) avs ();

  nios2_ocimem_monitor #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs                     (avs)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd,
                                       input logic clr_rdy, input logic clr_err);
    logic [37:0] j;
    j = '0;
    j[17 +: 8] = addr;
    j[34] = rd;
    j[35] = clr_rdy;
    j[36] = clr_err;
    return j;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic rd, input logic cr, input logic ce);
    $display("JTAG  action_a addr=%02h rd=%0d clr_rdy=%0d clr_err=%0d", addr, rd, cr, ce);
    jdo = mk_a(addr, rd, cr, ce);
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] data);
    $display("JTAG  action_b data=%08h", data);
    jdo = {3'b000, data, 3'b000};
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_next();
    $display("JTAG  no_action_a (read next)");
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_write(input logic [8:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output int stalls);
    avs.address = addr; avs.writedata = data; avs.byteenable = be;
    avs.chipselect = 1'b1; avs.write = 1'b1; avs.read = 1'b0;
    stalls = 0;
    #1;
    while (avs.waitrequest && stalls < 20) begin
      @(negedge clk); #1; stalls++;
    end
    if (stalls >= 20) begin
      checks++; errors++;
      $display("FAIL cpu_write_timeout: waitrequest still %0b, required 0", avs.waitrequest);
    end
    @(negedge clk);
    avs.chipselect = 1'b0; avs.write = 1'b0;
    $display("CPU   write addr=%03h data=%08h be=%04b stalls=%0d", addr, data, be, stalls);
  endtask

  task automatic cpu_read(input logic [8:0] addr, output logic [31:0] data, output int stalls);
    avs.address = addr; avs.byteenable = 4'hF;
    avs.chipselect = 1'b1; avs.read = 1'b1; avs.write = 1'b0;
    stalls = 0;
    #1;
    while (avs.waitrequest && stalls < 20) begin
      @(negedge clk); #1; stalls++;
    end
    if (stalls >= 20) begin
      checks++; errors++;
      $display("FAIL cpu_read_timeout: waitrequest still %0b, required 0", avs.waitrequest);
    end
    data = avs.readdata;
    @(negedge clk);
    avs.chipselect = 1'b0; avs.read = 1'b0;
    $display("CPU   read  addr=%03h data=%08h stalls=%0d", addr, data, stalls);
  endtask

  task automatic test_reset();
    logic [31:0] d; int s;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mondreg: got %08h required 00000000", MonDReg); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b required 0", monitor_ready); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b required 0", monitor_error); end
    checks++; if (avs.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %08h required 00000000", avs.readdata); end
    checks++; if (avs.waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitrequest: got %0b required 0", avs.waitrequest); end
    cpu_read(9'h101, d, s);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_monareg: got %08h required 00000000", d); end
  endtask

  task automatic test_jtag_write_read();
    logic [31:0] d; int s;
    jtag_a(8'h10, 1'b0, 1'b0, 1'b0);
    step(8);
    jtag_b(32'hDEADBEEF);
    step(8);
    jtag_a(8'h10, 1'b1, 1'b0, 1'b0);
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL jrd_early: got %08h required 00000000", MonDReg); end
    step(2);
    checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL jrd_data: got %08h required deadbeef", MonDReg); end
    cpu_read(9'h101, d, s);
    checks++; if (d !== 32'h11) begin errors++; $display("FAIL jrd_monareg: got %08h required 00000011", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; int s;
    cpu_write(9'h0FF, 32'h0F0F0F0F, 4'hF, s);
    cpu_write(9'h000, 32'h12345678, 4'hF, s);
    jtag_a(8'hFF, 1'b1, 1'b0, 1'b0);
    step(8);
    checks++; if (MonDReg !== 32'h0F0F0F0F) begin errors++; $display("FAIL wrap_first_data: got %08h required 0f0f0f0f", MonDReg); end
    cpu_read(9'h101, d, s);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_monareg0: got %08h required 00000000", d); end
    jtag_next();
    step(8);
    checks++; if (MonDReg !== 32'h12345678) begin errors++; $display("FAIL wrap_second_data: got %08h required 12345678", MonDReg); end
    cpu_read(9'h101, d, s);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL wrap_monareg1: got %08h required 00000001", d); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; int s;
    cpu_write(9'h005, 32'h11223344, 4'hF, s);
    checks++; if (s !== 0) begin errors++; $display("FAIL cpu_write_stalls: got %0d required 0", s); end
    cpu_write(9'h005, 32'hAABBCCDD, 4'b0010, s);
    cpu_read(9'h005, d, s);
    checks++; if (d !== 32'h1122CC44) begin errors++; $display("FAIL byte_lane_data: got %08h required 1122cc44", d); end
    checks++; if (s !== 1) begin errors++; $display("FAIL cpu_read_stalls: got %0d required 1", s); end
  endtask

  task automatic test_flags();
    logic [31:0] d; int s;
    cpu_write(9'h100, 32'h3, 4'hF, s);
    checks++; if ({monitor_error, monitor_ready} !== 2'b11) begin errors++; $display("FAIL flags_set: got err,rdy=%02b required 11", {monitor_error, monitor_ready}); end
    step(2);
    jtag_a(8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if ({monitor_error, monitor_ready} !== 2'b10) begin errors++; $display("FAIL flags_clr_rdy: got err,rdy=%02b required 10", {monitor_error, monitor_ready}); end
    cpu_read(9'h100, d, s);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL flags_status_read: got %08h required 00000002", d); end
    // Set both and clear error in the same cycle: error clear must win.
    $display("CPU   write addr=100 data=00000003 with JTAG clr_err same cycle");
    avs.address = 9'h100; avs.writedata = 32'h3; avs.byteenable = 4'hF;
    avs.chipselect = 1'b1; avs.write = 1'b1; avs.read = 1'b0;
    jdo = mk_a(8'h00, 1'b0, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    avs.chipselect = 1'b0; avs.write = 1'b0;
    checks++; if ({monitor_error, monitor_ready} !== 2'b01) begin errors++; $display("FAIL flags_clear_wins: got err,rdy=%02b required 01", {monitor_error, monitor_ready}); end
  endtask

  task automatic test_contention();
    int stalls; int n;
    jtag_a(8'h20, 1'b0, 1'b0, 1'b0);
    step(8);
    $display("CPU   read  addr=020 issued with JTAG write data=cafef00d");
    jdo = {3'b000, 32'hCAFEF00D, 3'b000};
    take_action_ocimem_b = 1'b1;
    avs.address = 9'h020; avs.chipselect = 1'b1; avs.read = 1'b1; avs.write = 1'b0;
    stalls = 0; n = 0;
    #1;
    while (avs.waitrequest && n < 20) begin
      stalls++;
      @(negedge clk);
      take_action_ocimem_b = 1'b0;
      #1; n++;
    end
    checks++; if (stalls !== 2) begin errors++; $display("FAIL contention_stalls: got %0d required 2", stalls); end
    checks++; if (avs.readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL contention_data: got %08h required cafef00d", avs.readdata); end
    @(negedge clk);
    avs.chipselect = 1'b0; avs.read = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic test_strobe_in_crd();
    jtag_a(8'h30, 1'b0, 1'b0, 1'b0);
    step(8);
    $display("CPU   read  addr=005 with JTAG write data=5a5a1234 during completion");
    avs.address = 9'h005; avs.chipselect = 1'b1; avs.read = 1'b1; avs.write = 1'b0;
    @(negedge clk);
    jdo = {3'b000, 32'h5A5A1234, 3'b000};
    take_action_ocimem_b = 1'b1;
    #1;
    checks++; if (avs.readdata !== 32'h1122CC44) begin errors++; $display("FAIL crd_readdata: got %08h required 1122cc44", avs.readdata); end
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    avs.chipselect = 1'b0; avs.read = 1'b0;
    step(8);
    jtag_a(8'h30, 1'b1, 1'b0, 1'b0);
    step(8);
    checks++; if (MonDReg !== 32'h5A5A1234) begin errors++; $display("FAIL crd_strobe_kept: got %08h required 5a5a1234", MonDReg); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int s;
    jtag_a(8'h10, 1'b1, 1'b0, 1'b0);
    step(1);
    reset_n = 1'b0;
    #1;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL midreset_mondreg: got %08h required 00000000", MonDReg); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %0b required 0", monitor_ready); end
    step(2);
    reset_n = 1'b1;
    step(3);
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL midreset_jrd_aborted: got %08h required 00000000", MonDReg); end
    checks++; if (avs.readdata !== 32'h0) begin errors++; $display("FAIL midreset_readdata: got %08h required 00000000", avs.readdata); end
    cpu_read(9'h101, d, s);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_monareg: got %08h required 00000000", d); end
    cpu_read(9'h010, d, s);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL midreset_ram_kept: got %08h required deadbeef", d); end
    checks++; if (s !== 1) begin errors++; $display("FAIL midreset_idle: got %0d stalls required 1", s); end
  endtask

  initial begin
    avs.address = '0; avs.chipselect = 1'b0; avs.read = 1'b0; avs.write = 1'b0;
    avs.writedata = '0; avs.byteenable = 4'hF;
    step(3);
    reset_n = 1'b1;
    step(1);
    test_reset();
    test_jtag_write_read();
    test_wrap();
    test_byte_lanes();
    test_flags();
    test_contention();
    test_strobe_in_crd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
